// File: rtl/vx_csr_rmw_arbiter.sv
// Round-robin arbiter that serialises atomic CSR read-modify-write transactions
// from NUM_REQS requesters onto the single read/write port pair of the CSR data block.
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef NW_BITS
`define NW_BITS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif

module vx_csr_rmw_arbiter #(
    parameter int NUM_REQS     = 2,
    parameter int REQ_SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQS-1:0]                          req_valid,
    output logic [NUM_REQS-1:0]                          req_ready,
    input  logic [NUM_REQS-1:0][1:0]                     req_op,
    input  logic [NUM_REQS-1:0][`CSR_ADDR_BITS-1:0]      req_addr,
    input  logic [NUM_REQS-1:0][`NW_BITS-1:0]            req_wid,
    input  logic [NUM_REQS-1:0][`UUID_BITS-1:0]          req_uuid,
    input  logic [NUM_REQS-1:0][31:0]                    req_data,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [REQ_SEL_BITS-1:0]                      rsp_idx,
    output logic [31:0]                                  rsp_data,
    output logic [`UUID_BITS-1:0]                        rsp_uuid,
    output logic                                         read_enable,
    output logic [`CSR_ADDR_BITS-1:0]                    read_addr,
    output logic [`NW_BITS-1:0]                          read_wid,
    output logic [`UUID_BITS-1:0]                        read_uuid,
    input  logic [31:0]                                  read_data,
    output logic                                         write_enable,
    output logic [`CSR_ADDR_BITS-1:0]                    write_addr,
    output logic [`NW_BITS-1:0]                          write_wid,
    output logic [`UUID_BITS-1:0]                        write_uuid,
    output logic [31:0]                                  write_data,
    output logic                                         busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RSP} state_t;

    localparam logic [1:0] OP_RW = 2'd0;
    localparam logic [1:0] OP_RS = 2'd1;
    localparam logic [1:0] OP_RC = 2'd2;

    typedef struct packed {
        logic [1:0]                op;
        logic [`CSR_ADDR_BITS-1:0] addr;
        logic [`NW_BITS-1:0]       wid;
        logic [`UUID_BITS-1:0]     uuid;
        logic [31:0]               data;
    } req_t;

    state_t                  state;
    req_t                    cur;
    logic [REQ_SEL_BITS-1:0] idx_r;
    logic [REQ_SEL_BITS-1:0] rr_ptr;
    logic [31:0]             old_r;

    logic                    gnt_any;
    logic [REQ_SEL_BITS-1:0] gnt_idx;
    logic [REQ_SEL_BITS-1:0] nxt_ptr;
    logic                    do_write;
    logic [31:0]             new_val;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQS]) begin
                gnt_any = 1'b1;
                gnt_idx = REQ_SEL_BITS'((int'(rr_ptr) + k) % NUM_REQS);
            end
        end
    end

    assign nxt_ptr = (NUM_REQS == 1 || gnt_idx == REQ_SEL_BITS'(NUM_REQS - 1))
                   ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cur    <= '0;
            idx_r  <= '0;
            rr_ptr <= '0;
            old_r  <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    cur.op   <= req_op[gnt_idx];
                    cur.addr <= req_addr[gnt_idx];
                    cur.wid  <= req_wid[gnt_idx];
                    cur.uuid <= req_uuid[gnt_idx];
                    cur.data <= req_data[gnt_idx];
                    idx_r    <= gnt_idx;
                    rr_ptr   <= nxt_ptr;
                    state    <= READ;
                end
                READ: begin
                    old_r <= read_data;
                    state <= WRITE;
                end
                WRITE: state <= RSP;
                RSP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (cur.op)
            OP_RW:   new_val = cur.data;
            OP_RS:   new_val = old_r | cur.data;
            OP_RC:   new_val = old_r & ~cur.data;
            default: new_val = old_r;
        endcase
    end

    // Set/clear with an empty mask leave the CSR untouched, so skip the write.
    assign do_write = (cur.op == OP_RW) ||
                      ((cur.op == OP_RS || cur.op == OP_RC) && cur.data != 32'd0);

    // Gating by reset keeps every output quiet while reset is held, including
    // the WRITE cycle in which reset is first asserted.
    assign busy         = reset && (state != IDLE);
    assign req_ready    = (reset && state == IDLE && gnt_any) ? (NUM_REQS'(1) << gnt_idx) : '0;

    assign read_enable  = reset && (state == READ);
    assign read_addr    = busy ? cur.addr : '0;
    assign read_wid     = busy ? cur.wid  : '0;
    assign read_uuid    = busy ? cur.uuid : '0;

    assign write_enable = reset && (state == WRITE) && do_write;
    assign write_addr   = busy ? cur.addr : '0;
    assign write_wid    = busy ? cur.wid  : '0;
    assign write_uuid   = busy ? cur.uuid : '0;
    assign write_data   = write_enable ? new_val : 32'd0;

    assign rsp_valid    = reset && (state == RSP);
    assign rsp_data     = rsp_valid ? old_r    : 32'd0;
    assign rsp_idx      = rsp_valid ? idx_r    : '0;
    assign rsp_uuid     = rsp_valid ? cur.uuid : '0;

endmodule

// File: tb/tb_vx_csr_rmw_arbiter.sv
// Directed bench for vx_csr_rmw_arbiter: vector table for single RMW transactions,
// plus sequences for backpressure, reset in the WRITE cycle and round-robin fairness.
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef NW_BITS
`define NW_BITS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif

module tb_vx_csr_rmw_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]                     req_valid, req_ready;
    logic [N-1:0][1:0]                req_op;
    logic [N-1:0][`CSR_ADDR_BITS-1:0] req_addr;
    logic [N-1:0][`NW_BITS-1:0]       req_wid;
    logic [N-1:0][`UUID_BITS-1:0]     req_uuid;
    logic [N-1:0][31:0]               req_data;
    logic                             rsp_valid, rsp_ready;
    logic [0:0]                       rsp_idx;
    logic [31:0]                      rsp_data;
    logic [`UUID_BITS-1:0]            rsp_uuid;
    logic                             read_enable, write_enable, busy;
    logic [`CSR_ADDR_BITS-1:0]        read_addr, write_addr;
    logic [`NW_BITS-1:0]              read_wid, write_wid;
    logic [`UUID_BITS-1:0]            read_uuid, write_uuid;
    logic [31:0]                      read_data, write_data;

    vx_csr_rmw_arbiter #(.NUM_REQS(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wid(req_wid), .req_uuid(req_uuid), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx),
        .rsp_data(rsp_data), .rsp_uuid(rsp_uuid),
        .read_enable(read_enable), .read_addr(read_addr), .read_wid(read_wid),
        .read_uuid(read_uuid), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_wid(write_wid),
        .write_uuid(write_uuid), .write_data(write_data), .busy(busy)
    );

    // Single-register CSR model; preload lets the bench set the prior value.
    logic [31:0] csr_q;
    logic [31:0] preload_val;
    logic        preload_en;
    assign read_data = csr_q;
    always @(posedge clk) begin
        if (preload_en) csr_q <= preload_val;
        else if (write_enable) csr_q <= write_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic        pre;
        logic [31:0] prior;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic preload(input logic [31:0] v);
        preload_val = v;
        preload_en  = 1'b1;
        @(posedge clk); #1;
        preload_en  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        if (v.pre) preload(v.prior);
        req_valid   = 2'b01;
        req_op[0]   = v.op;
        req_data[0] = v.data;
        req_addr[0] = 12'h340;
        req_wid[0]  = i[3:0];
        req_uuid[0] = 44'(100 + i);
        @(negedge clk);
        chk("grant", req_ready, 2'b01);
        chk("c0_busy", busy, 1'b0);
        chk("c0_we", write_enable, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rd_en", read_enable, 1'b1);
        chk("rd_addr", read_addr, 12'h340);
        chk("rd_wid", read_wid, i[3:0]);
        chk("c1_we", write_enable, 1'b0);
        @(negedge clk);
        chk("wr_en", write_enable, v.we);
        if (v.we) chk("wr_data", write_data, v.wdata);
        chk("c2_rd_en", read_enable, 1'b0);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_data", rsp_data, v.rdata);
        chk("rsp_idx", rsp_idx, 1'b0);
        chk("rsp_uuid", rsp_uuid, 44'(100 + i));
        chk("c3_we", write_enable, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int last;
        vecs[0] = '{2'd0, 32'hDEAD_BEEF, 1'b1, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234};
        vecs[1] = '{2'd1, 32'h0000_000F, 1'b1, 32'h0000_00F0, 1'b1, 32'h0000_00FF, 32'h0000_00F0};
        vecs[2] = '{2'd2, 32'h0000_00F0, 1'b0, 32'h0,         1'b1, 32'h0000_000F, 32'h0000_00FF};
        vecs[3] = '{2'd1, 32'h0,         1'b1, 32'h0000_0055, 1'b0, 32'h0,         32'h0000_0055};
        vecs[4] = '{2'd2, 32'h0,         1'b1, 32'h0000_00AA, 1'b0, 32'h0,         32'h0000_00AA};
        vecs[5] = '{2'd3, 32'h0000_FFFF, 1'b1, 32'h0000_0077, 1'b0, 32'h0,         32'h0000_0077};
        vecs[6] = '{2'd3, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0077};
        vecs[7] = '{2'd2, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 1'b1, 32'h0,         32'h1234_5678};

        reset = 1'b0; preload_en = 1'b0; preload_val = '0;
        req_valid = 2'b01; req_op = '0; req_addr = '0; req_wid = '0; req_uuid = '0; req_data = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rd_en", read_enable, 1'b0);
        chk("rst_wr_en", write_enable, 1'b0);
        chk("rst_rd_addr", read_addr, 12'h0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Response backpressure with req1 pending behind it.
        preload(32'h0000_CAFE);
        rsp_ready = 1'b0;
        req_valid = 2'b01; req_op[0] = 2'd0; req_data[0] = 32'h0000_BEEF; req_uuid[0] = 44'h55;
        @(negedge clk);
        chk("bp_grant0", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b10; req_op[1] = 2'd3; req_addr[1] = 12'h341; req_uuid[1] = 44'h66;
        @(negedge clk);
        @(negedge clk);
        chk("bp_wr_en", write_enable, 1'b1);
        chk("bp_wr_data", write_data, 32'h0000_BEEF);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 32'h0000_CAFE);
            chk("bp_rsp_idx", rsp_idx, 1'b0);
            chk("bp_busy", busy, 1'b1);
            chk("bp_req_ready", req_ready, 2'b00);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("bp_hs_req_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_grant1", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("bp1_rd_addr", read_addr, 12'h341);
        @(negedge clk);
        chk("bp1_wr_en", write_enable, 1'b0);
        @(negedge clk);
        chk("bp1_rsp_idx", rsp_idx, 1'b1);
        chk("bp1_rsp_data", rsp_data, 32'h0000_BEEF);
        chk("bp1_rsp_uuid", rsp_uuid, 44'h66);
        @(posedge clk); #1;

        // Reset asserted in the WRITE cycle; both requesters stay valid.
        preload(32'h0000_1111);
        req_valid = 2'b11; req_op[0] = 2'd0; req_data[0] = 32'h0000_2222; req_addr[0] = 12'h340;
        req_op[1] = 2'd0; req_data[1] = 32'h0000_3333; req_addr[1] = 12'h342;
        @(negedge clk);
        chk("rm_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rm_wr_en", write_enable, 1'b0);
        chk("rm_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_req_ready", req_ready, 2'b00);
        chk("rm_busy", busy, 1'b0);
        chk("rm_rsp_valid2", rsp_valid, 1'b0);
        chk("rm_rd_en", read_enable, 1'b0);
        chk("rm_wr_en2", write_enable, 1'b0);
        chk("rm_wr_addr", write_addr, 12'h0);
        chk("rm_rsp_data", rsp_data, 32'h0);
        chk("rm_csr_kept", csr_q, 32'h0000_1111);
        @(posedge clk); #1;
        reset = 1'b1;

        // Round-robin with both requesters always valid: req0 first after reset.
        last = 0;
        for (int g = 0; g < 20; g++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == 2'b00 && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (n >= 10) begin
                chk("rr_timeout", n, 0);
                break;
            end
            chk("rr_grant", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            if (g > 0) chk("rr_spacing", cyc - last, 4);
            last = cyc;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            chk("rr_rsp_idx", rsp_idx, g % 2);
        end
        req_valid = 2'b00;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
